// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 field widths, flag indices, rounding modes and arbiter states
package fpu_pkg;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int FP_W   = 1 + EXP_W + MAN_W;
  localparam int FLAG_W = 5;

  // Flag vector order is {invalid,overflow,underflow,inexact,zero}
  localparam int FLAG_ZERO      = 0;
  localparam int FLAG_INEXACT   = 1;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_OVERFLOW  = 3;
  localparam int FLAG_INVALID   = 4;

  localparam logic [1:0] RM_NEAREST_EVEN = 2'b00;
  localparam logic [1:0] RM_TO_ZERO      = 2'b01;
  localparam logic [1:0] RM_POS_INF      = 2'b10;
  localparam logic [1:0] RM_NEG_INF      = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mul_state_t;
endpackage

// File: rtl/fpu_rr_arb2.sv
// rtl/fpu_rr_arb2.sv - 2-way combinational arbiter; FPU_MUL_FIXED_PRIO_EN selects fixed port-0 priority
module fpu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
`ifdef FPU_MUL_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ptr;
  assign gnt = req[0] ? 2'b01 : {req[1], 1'b0};
`else
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end
`endif
endmodule

// File: rtl/fpu_mul_arbiter.sv
// rtl/fpu_mul_arbiter.sv - shares one combinational FP32 multiplier between two requesters; FPU_MUL_FIXED_PRIO_EN drops round-robin
module fpu_mul_arbiter
  import fpu_pkg::*;
#(
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [FP_W-1:0]   req_x0,
  input  logic [FP_W-1:0]   req_y0,
  input  logic [FP_W-1:0]   req_x1,
  input  logic [FP_W-1:0]   req_y1,
  input  logic [1:0]        req_rmode0,
  input  logic [1:0]        req_rmode1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [FP_W-1:0]   rsp_z,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [FP_W-1:0]   mul_x,
  output logic [FP_W-1:0]   mul_y,
  output logic [1:0]        mul_rmode,
  input  logic [FP_W-1:0]   mul_z,
  input  logic [FLAG_W-1:0] mul_flags,
  output logic [FLAG_W-1:0] sticky_flags,
  input  logic              flag_clr,
  output logic              busy
);
  mul_state_t       r_state;
  logic             r_gnt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_ptr;
  logic [1:0]       w_arb_gnt;
  logic             w_sel;
  logic             w_capture;
  logic             w_rsp_acc;

`ifdef FPU_MUL_FIXED_PRIO_EN
  assign w_ptr = 1'b0;
`else
  logic r_rr_ptr;
  assign w_ptr = r_rr_ptr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_rr_ptr <= 1'b0;
    else if (w_rsp_acc) r_rr_ptr <= ~r_gnt;
  end
`endif

  fpu_rr_arb2 u_arb (
    .req (req_valid),
    .ptr (w_ptr),
    .gnt (w_arb_gnt)
  );

  assign w_sel     = w_arb_gnt[1];
  assign req_ready = (r_state == ST_IDLE) ? w_arb_gnt : 2'b00;
  assign w_capture = (r_state == ST_WAIT) && (r_cnt == '0);
  assign w_rsp_acc = (r_state == ST_RESP) && rsp_ready[r_gnt];
  assign busy      = (r_state != ST_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_gnt        <= 1'b0;
      r_cnt        <= '0;
      rsp_valid    <= 2'b00;
      rsp_z        <= '0;
      rsp_flags    <= '0;
      mul_x        <= '0;
      mul_y        <= '0;
      mul_rmode    <= 2'b00;
      sticky_flags <= '0;
    end else begin
      // A clear coinciding with a capture keeps only the newly captured flags
      sticky_flags <= (flag_clr ? '0 : sticky_flags) | (w_capture ? mul_flags : '0);
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            mul_x     <= w_sel ? req_x1 : req_x0;
            mul_y     <= w_sel ? req_y1 : req_y0;
            mul_rmode <= w_sel ? req_rmode1 : req_rmode0;
            r_gnt     <= w_sel;
            r_cnt     <= CNT_W'(MUL_LAT - 1);
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            rsp_z     <= mul_z;
            rsp_flags <= mul_flags;
            rsp_valid <= r_gnt ? 2'b10 : 2'b01;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_rsp_acc) begin
            rsp_valid <= 2'b00;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// tb/tb_fpu_mul_arbiter.sv - directed vector bench for fpu_mul_arbiter at MUL_LAT 1, 4, 3 and 15
`timescale 1ns/1ps
module tb_fpu_mul_arbiter;
  localparam int NI = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic        RST          [NI];
  logic [1:0]  req_valid    [NI];
  logic [1:0]  req_ready    [NI];
  logic [31:0] req_x0       [NI];
  logic [31:0] req_y0       [NI];
  logic [31:0] req_x1       [NI];
  logic [31:0] req_y1       [NI];
  logic [1:0]  req_rmode0   [NI];
  logic [1:0]  req_rmode1   [NI];
  logic [1:0]  rsp_valid    [NI];
  logic [1:0]  rsp_ready    [NI];
  logic [31:0] rsp_z        [NI];
  logic [4:0]  rsp_flags    [NI];
  logic [31:0] mul_x        [NI];
  logic [31:0] mul_y        [NI];
  logic [1:0]  mul_rmode    [NI];
  logic [31:0] mul_z        [NI];
  logic [4:0]  mul_flags    [NI];
  logic [4:0]  sticky_flags [NI];
  logic        flag_clr     [NI];
  logic        busy         [NI];

  // Stand-in for Top_MUL: only the operand pairs used here have known products
  function automatic logic [36:0] mul_model(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      {32'h40000000, 32'h40400000}: return {32'h40C00000, 5'b00000};
      {32'h3FC00000, 32'h40000000}: return {32'h40400000, 5'b00000};
      {32'hBF800000, 32'h40800000}: return {32'hC0800000, 5'b00000};
      {32'h7F800000, 32'h00000000}: return {32'h7FC00000, 5'b10000};
      {32'h7F7FFFFF, 32'h40000000}: return {32'h7F800000, 5'b01010};
      default:                      return {32'hDEADBEEF, 5'b11111};
    endcase
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : (k == 2) ? 3 : 15;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 3 : 15;
    fpu_mul_arbiter #(.MUL_LAT(L), .CNT_W(4)) u_dut (
      .CLK(CLK), .RST(RST[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_x0(req_x0[g]), .req_y0(req_y0[g]), .req_x1(req_x1[g]), .req_y1(req_y1[g]),
      .req_rmode0(req_rmode0[g]), .req_rmode1(req_rmode1[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_z(rsp_z[g]), .rsp_flags(rsp_flags[g]),
      .mul_x(mul_x[g]), .mul_y(mul_y[g]), .mul_rmode(mul_rmode[g]),
      .mul_z(mul_z[g]), .mul_flags(mul_flags[g]),
      .sticky_flags(sticky_flags[g]), .flag_clr(flag_clr[g]), .busy(busy[g])
    );
    assign {mul_z[g], mul_flags[g]} = mul_model(mul_x[g], mul_y[g]);
  end

  typedef struct {
    int          port;
    logic [31:0] x;
    logic [31:0] y;
    logic [1:0]  rm;
    logic        clr;
    logic [31:0] z;
    logic [4:0]  fl;
    logic [4:0]  st;
  } vec_t;
  vec_t vt [6];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_reset(input int k, input string nm);
    chk({nm, "_rdy_vld"}, {62'd0, req_ready[k] | rsp_valid[k]}, 64'd0);
    chk({nm, "_rsp_z"}, {32'd0, rsp_z[k]}, 64'd0);
    chk({nm, "_flags"}, {54'd0, rsp_flags[k], sticky_flags[k]}, 64'd0);
    chk({nm, "_mul_xy"}, {mul_x[k], mul_y[k]}, 64'd0);
    chk({nm, "_rm_busy"}, {61'd0, mul_rmode[k], busy[k]}, 64'd0);
  endtask

  task automatic run_op(input int k, input vec_t v, input bit chk_sticky);
    int acc;
    bit ok;
    if (v.port == 0) begin
      req_x0[k] = v.x; req_y0[k] = v.y; req_rmode0[k] = v.rm;
    end else begin
      req_x1[k] = v.x; req_y1[k] = v.y; req_rmode1[k] = v.rm;
    end
    req_valid[k][v.port] = 1'b1;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready[k][v.port]) begin ok = 1'b1; break; end
      tick(); #1;
    end
    chk("accept_seen", 64'(ok), 64'd1);
    chk("ready_onehot", 64'(req_ready[k]), 64'(2'b01 << v.port));
    acc = cyc;
    tick();
    req_valid[k][v.port] = 1'b0;
    chk("busy_in_wait", 64'(busy[k]), 64'd1);
    chk("mul_operands", {mul_x[k], mul_y[k]}, {v.x, v.y});
    chk("mul_rmode", 64'(mul_rmode[k]), 64'(v.rm));
    if (v.clr) flag_clr[k] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid[k] != 2'b00) begin ok = 1'b1; break; end
      tick();
      flag_clr[k] = 1'b0;
    end
    flag_clr[k] = 1'b0;
    chk("rsp_seen", 64'(ok), 64'd1);
    chk("latency", 64'(cyc - acc), 64'(lat_of(k) + 1));
    chk("rsp_onehot", 64'(rsp_valid[k]), 64'(2'b01 << v.port));
    chk("rsp_z", 64'(rsp_z[k]), 64'(v.z));
    chk("rsp_flags", 64'(rsp_flags[k]), 64'(v.fl));
    if (chk_sticky) chk("sticky", 64'(sticky_flags[k]), 64'(v.st));
    rsp_ready[k][v.port] = 1'b1;
    tick();
    rsp_ready[k] = 2'b00;
    chk("idle_after", {62'd0, busy[k], |rsp_valid[k]}, 64'd0);
    chk("mul_x_held", 64'(mul_x[k]), 64'(v.x));
  endtask

  initial begin
    logic [1:0]  exp_order [4];
    logic [1:0]  pend;
    logic [31:0] hold_z;
    int          ngr;
    int          last;
    bit          seen;

    vt[0] = '{0, 32'h40000000, 32'h40400000, 2'b00, 1'b0, 32'h40C00000, 5'b00000, 5'b00000};
    vt[1] = '{1, 32'h3FC00000, 32'h40000000, 2'b01, 1'b0, 32'h40400000, 5'b00000, 5'b00000};
    vt[2] = '{0, 32'hBF800000, 32'h40800000, 2'b10, 1'b0, 32'hC0800000, 5'b00000, 5'b00000};
    vt[3] = '{1, 32'h7F800000, 32'h00000000, 2'b11, 1'b0, 32'h7FC00000, 5'b10000, 5'b10000};
    vt[4] = '{0, 32'h40000000, 32'h40400000, 2'b00, 1'b0, 32'h40C00000, 5'b00000, 5'b10000};
    vt[5] = '{1, 32'h7F7FFFFF, 32'h40000000, 2'b00, 1'b1, 32'h7F800000, 5'b01010, 5'b01010};
`ifdef FPU_MUL_FIXED_PRIO_EN
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

    for (int k = 0; k < NI; k++) begin
      RST[k] = 1'b1; req_valid[k] = 2'b00; rsp_ready[k] = 2'b00; flag_clr[k] = 1'b0;
      req_x0[k] = '0; req_y0[k] = '0; req_x1[k] = '0; req_y1[k] = '0;
      req_rmode0[k] = 2'b00; req_rmode1[k] = 2'b00;
    end
    tick(); tick();
    chk_reset(0, "reset0");
    chk_reset(3, "reset3");
    for (int k = 0; k < NI; k++) RST[k] = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_op(0, vt[i], 1'b1);

    // Both ports held valid, responses always accepted
    RST[0] = 1'b1; #1; tick(); RST[0] = 1'b0;
    req_x0[0] = 32'h3FC00000; req_y0[0] = 32'h40000000;
    req_x1[0] = 32'hBF800000; req_y1[0] = 32'h40800000;
    rsp_ready[0] = 2'b11; req_valid[0] = 2'b11;
    ngr = 0; last = 0; pend = 2'b00;
    for (int i = 0; i < 40 && ngr < 4; i++) begin
      #1;
      if (rsp_valid[0] != 2'b00) begin
        chk("fair_rsp_port", 64'(rsp_valid[0]), 64'(pend));
        chk("fair_rsp_z", 64'(rsp_z[0]), (pend == 2'b01) ? 64'h40400000 : 64'hC0800000);
      end
      if (req_ready[0] != 2'b00) begin
        chk("fair_gnt", 64'(req_ready[0]), 64'(exp_order[ngr]));
        if (ngr > 0) chk("fair_spacing", 64'(cyc - last), 64'd3);
        pend = req_ready[0];
        last = cyc; ngr++;
      end
      tick();
    end
    chk("fair_count", 64'(ngr), 64'd4);
    req_valid[0] = 2'b00;
    repeat (4) tick();
    rsp_ready[0] = 2'b00;
    chk("fair_drained", 64'(busy[0]), 64'd0);

    // Response backpressure with a competing request on port 1
    req_x0[0] = 32'h40000000; req_y0[0] = 32'h40400000; req_valid[0] = 2'b01;
    #1; chk("bp_accept", 64'(req_ready[0]), 64'd1);
    tick(); req_valid[0] = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rsp_valid[0] != 2'b00) seen = 1'b1; else tick();
    end
    chk("bp_rsp_seen", 64'(seen), 64'd1);
    hold_z = 32'h40C00000;
    rsp_ready[0] = 2'b10;
    req_x1[0] = 32'h3FC00000; req_y1[0] = 32'h40000000; req_valid[0] = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_valid", 64'(rsp_valid[0]), 64'd1);
      chk("bp_hold_data", {27'd0, rsp_z[0], rsp_flags[0]}, {27'd0, hold_z, 5'b00000});
      chk("bp_no_ready", 64'(req_ready[0]), 64'd0);
      tick();
    end
    rsp_ready[0] = 2'b01;
    tick(); rsp_ready[0] = 2'b00;
    #1; chk("bp_pending_gnt", 64'(req_ready[0]), 64'd2);
    tick(); req_valid[0] = 2'b00;
    tick(); #1;
    chk("bp_port1_rsp", {30'd0, rsp_valid[0], rsp_z[0]}, {30'd0, 2'b10, 32'h40400000});
    rsp_ready[0] = 2'b10; tick(); rsp_ready[0] = 2'b00;

    // Reset two cycles into a four-cycle settle
    req_x0[1] = 32'h40000000; req_y0[1] = 32'h40400000; req_valid[1] = 2'b01;
    #1; chk("rst_accept", 64'(req_ready[1]), 64'd1);
    tick(); req_valid[1] = 2'b00;
    tick();
    chk("rst_busy_before", 64'(busy[1]), 64'd1);
    RST[1] = 1'b1; #1;
    chk_reset(1, "rst_mid_wait");
    tick(); RST[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid[1] != 2'b00 || busy[1]) seen = 1'b1;
      tick();
    end
    chk("rst_no_rsp", 64'(seen), 64'd0);
    run_op(1, vt[0], 1'b0);

    run_op(2, vt[0], 1'b0);
    run_op(3, vt[2], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
